seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial-pattern detector. It samples one bit per qualified clock from a serial input stream and pulses `z` when the most recent `LEN` bits equal `PATTERN`. It succeeds the fixed single-pattern sequence FSM and adds configurable pattern and length, a bit-valid qualifier, run-time overlapping or non-overlapping detection, and an optional match counter. It sits directly on a serial bit stream, upstream of control logic that consumes one-cycle match pulses.

## Interface
Parameters:
- `LEN`, 3: pattern length in bits; legal range 2..32.
- `PATTERN`, 3'b101: `LEN`-bit target; MSB is the oldest bit and LSB is the newest.
- `CNT_W`, 8: match counter width; used only with `SEQ_DET_COUNT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `en` in 1: bit-valid qualifier; `x` is consumed only when `en`=1.
- `x` in 1: serial input bit.
- `overlap` in 1: 1 = overlapping detection, 0 = non-overlapping; sampled with each consumed bit.
- `z` out 1: registered match pulse.
- `armed` out 1: 1 when `LEN` valid bits are held (state ARMED).
- `match_count` out `CNT_W`: saturating match count; present only with `SEQ_DET_COUNT_EN`.

## Operation
- State: history register `hist[LEN-1:0]`, fill counter `fill` (0..`LEN`, saturating), registered `z`.
- FSM states are FILL (`fill`<`LEN`) and ARMED (`fill`==`LEN`).
- Reset values: `hist`=0, `fill`=0 (FILL), `z`=0, `armed`=0, `match_count`=0.
- On an edge with `en`=1:
  - `hist_n` = {`hist[LEN-2:0]`, `x`}.
  - `fill_n` = min(`fill`+1, `LEN`).
  - match = (`fill_n`==`LEN`) && (`hist_n`==`PATTERN`).
- On match:
  - `z`<=1.
  - If `overlap`=1, `fill`<=`LEN` (stays ARMED, so the match bits can be reused).
  - If `overlap`=0, `fill`<=0 (returns to FILL; all history bits are discarded).
- No match: `z`<=0, `hist`<=`hist_n`, `fill`<=`fill_n`.
- On an edge with `en`=0: `hist` and `fill` hold, and `z`<=0. Gaps in `en` are invisible to detection.
- Transitions:
  - FILL→ARMED when the `LEN`-th bit is consumed without a match.
  - FILL→FILL when that bit matches and `overlap`=0.
  - ARMED→FILL on a match with `overlap`=0.
  - ARMED→ARMED otherwise.
- A match can occur no earlier than the `LEN`-th consumed bit after reset or after a non-overlapping match.
- `armed` = (`fill`==`LEN`), decoded from registered state.

## Timing
- Latency: `z` goes high in the cycle after the edge that consumes the completing bit. It lasts exactly one cycle per match.
- Back-to-back matches (overlap=1, self-overlapping pattern, continuous `en`) give `z` high on consecutive or spaced cycles, one pulse per match with none merged.
- Reset has priority over `en`. Reset asserted mid-sequence discards partial history. The first match after reset release requires `LEN` fresh bits.
- A toggle of `overlap` takes effect on the edge where it is sampled together with a consumed bit. There is no retroactive effect.
- `match_count` updates on the same edge that sets `z`, so it is visible in the same cycle as the pulse.

## Configuration
- `SEQ_DET_COUNT_EN` defined:
  - `match_count` port and counter are present.
  - The counter increments by 1 per match and saturates at 2^`CNT_W`−1. It does not wrap.
  - Only `reset` clears it.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Defaults, overlap=1, `en`=1: stream 0,0,1,0,1,1,1,0,1,1,1,0,1 → `z` pulses after bits 5, 9 and 13 (3 pulses); `match_count`=3.
- Defaults, stream 1,0,1,0,1: overlap=1 → 2 pulses, after bits 3 and 5. overlap=0 → 1 pulse, after bit 3, with `armed`=0 on the following cycle.
- Reset mid-sequence: bits 1,0 → reset for 1 cycle → bit 1 → no pulse, `armed`=0. Then 0,1 → 1 pulse.
- `en` gaps: bit 1 (en=1), three cycles with en=0 and x=1, then bits 0,1 → exactly 1 pulse. `z` stays 0 during the gaps.
- `CNT_W`=2, overlap=1, stream 1,0,1,0,1,0,1,0,1,0,1 (5 matches) → 5 pulses; `match_count` saturates at 3.
- `LEN`=5, `PATTERN`=5'b11011, overlap=1: stream 1,1,0,1,1,0,1,1 → pulses after bits 5 and 8.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Parametrised serial-pattern detector. Shifts in one bit per cycle while
// en=1 and raises a one-cycle registered pulse on z when the newest LEN
// consumed bits equal PATTERN (MSB = oldest bit, LSB = newest bit).
// overlap=1 keeps the matched bits for reuse; overlap=0 discards them, so
// LEN fresh bits are needed before the next match.
// Optional feature: define SEQ_DET_COUNT_EN to add a saturating match
// counter on port match_count (width CNT_W).
module seq_detector_param #(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    output logic             z,
    output logic             armed
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    // fill counts 0..LEN, so it needs enough bits to hold LEN itself
    localparam int             FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(LEN);

    // FILL: fewer than LEN valid history bits; ARMED: LEN valid bits held
    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t          state;
    logic [LEN-1:0]  hist;
    logic [FW-1:0]   fill;
    logic [LEN-1:0]  hist_n;
    logic [FW-1:0]   fill_n;
    logic            match;

    // next history / fill level if the current bit is consumed, and match test
    always_comb begin
        hist_n = {hist[LEN-2:0], x};
        fill_n = (fill == FULL) ? FULL : fill + 1'b1;
        match  = (fill_n == FULL) && (hist_n == PATTERN);
    end

    // detector FSM: history shift, fill level, state and registered pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            state <= S_FILL;
            z     <= 1'b0;
        end else begin
            // z is a single-cycle pulse; it only rises on a consumed match
            z <= 1'b0;
            if (en) begin
                if (match) begin
                    z <= 1'b1;
                    if (overlap) begin
                        // keep the matched bits so they can start the next match
                        hist  <= hist_n;
                        fill  <= FULL;
                        state <= S_ARMED;
                    end else begin
                        // discard all history; next match needs LEN fresh bits
                        hist  <= '0;
                        fill  <= '0;
                        state <= S_FILL;
                    end
                end else begin
                    hist  <= hist_n;
                    fill  <= fill_n;
                    state <= (fill_n == FULL) ? S_ARMED : S_FILL;
                end
            end
        end
    end

    // state is kept in lockstep with fill, so this equals (fill == LEN)
    assign armed = (state == S_ARMED);

`ifdef SEQ_DET_COUNT_EN
    // saturating match counter, updated on the same edge that raises z
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (en && match && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// Directed bench for seq_detector_param. Three instances share one set of
// inputs: defaults (LEN=3, 101, CNT_W=8), a CNT_W=2 copy for counter
// saturation, and a LEN=5 / 11011 instance. Expected pulse trains are
// hand-written strings, one character per clock cycle.
// Build with SEQ_DET_COUNT_EN defined to also check match_count.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic x;
    logic overlap;

    logic z_a, armed_a;
    logic z_c, armed_c;
    logic z_b, armed_b;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] cnt_a;
    logic [1:0] cnt_c;
    logic [7:0] cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    seq_detector_param #(.LEN(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
        .z(z_a), .armed(armed_a)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_a)
`endif
    );

    seq_detector_param #(.LEN(3), .PATTERN(3'b101), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
        .z(z_c), .armed(armed_c)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_c)
`endif
    );

    seq_detector_param #(.LEN(5), .PATTERN(5'b11011), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
        .z(z_b), .armed(armed_b)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_b)
`endif
    );

    // one comparison: counts it, and counts/reports it on failure
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: present inputs at negedge, let the posedge consume them, sample 1ns later
    task automatic step(input logic en_v, input logic x_v, input logic ov_v);
        @(negedge clk);
        en      = en_v;
        x       = x_v;
        overlap = ov_v;
        @(posedge clk);
        #1;
    endtask

    // one-cycle synchronous reset (en=1, x=1 held to show reset priority)
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset   = 1'b1;
        en      = 1'b1;
        x       = 1'b1;
        overlap = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rst_z"}, 32'(z_a), 32'd0);
        chk({tag, "_rst_armed"}, 32'(armed_a), 32'd0);
        chk({tag, "_rst_z_b"}, 32'(z_b), 32'd0);
`ifdef SEQ_DET_COUNT_EN
        chk({tag, "_rst_cnt"}, 32'(cnt_a), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
    endtask

    // drive a bit string with en=1 and check z of the selected instance per bit
    // sel: 0 = dut_a, 1 = dut_c, 2 = dut_b
    task automatic run_stream(input string tag, input int sel, input string bits,
                              input string exp_z, input logic ov);
        logic zv;
        for (int i = 0; i < bits.len(); i++) begin
            step(1'b1, bits[i] == "1", ov);
            zv = (sel == 0) ? z_a : (sel == 1) ? z_c : z_b;
            chk($sformatf("%s_z_bit%0d", tag, i + 1), 32'(zv), 32'(exp_z[i] == "1"));
        end
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b0;
        x       = 1'b0;
        overlap = 1'b1;
        repeat (2) @(negedge clk);

        // overlapping detection on a long stream, three spaced pulses
        do_reset("t1");
        run_stream("t1", 0, "0010111011101", "0000100010001", 1'b1);
        chk("t1_armed_end", 32'(armed_a), 32'd1);
`ifdef SEQ_DET_COUNT_EN
        chk("t1_cnt", 32'(cnt_a), 32'd3);
`endif

        // 10101 with overlap: pulses after bits 3 and 5
        do_reset("t2a");
        run_stream("t2a", 0, "101", "001", 1'b1);
        chk("t2a_armed_bit3", 32'(armed_a), 32'd1);
        run_stream("t2a_tail", 0, "01", "01", 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk("t2a_cnt", 32'(cnt_a), 32'd2);
`endif

        // 10101 without overlap: single pulse, back to FILL afterwards
        do_reset("t2b");
        run_stream("t2b", 0, "101", "001", 1'b0);
        chk("t2b_armed_bit3", 32'(armed_a), 32'd0);
        run_stream("t2b_tail", 0, "01", "00", 1'b0);
        chk("t2b_armed_bit5", 32'(armed_a), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t2b_idle_z", 32'(z_a), 32'd0);
`ifdef SEQ_DET_COUNT_EN
        chk("t2b_cnt", 32'(cnt_a), 32'd1);
`endif

        // reset mid-sequence discards the partial 1,0
        do_reset("t3");
        run_stream("t3_pre", 0, "10", "00", 1'b1);
        do_reset("t3mid");
        run_stream("t3_post", 0, "1", "0", 1'b1);
        chk("t3_armed", 32'(armed_a), 32'd0);
        run_stream("t3_fin", 0, "01", "01", 1'b1);

        // en gaps are invisible: 1, (gap x3 with x=1), 0, 1 -> one pulse
        do_reset("t4");
        run_stream("t4_a", 0, "1", "0", 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("t4_gap%0d_z", g), 32'(z_a), 32'd0);
            chk($sformatf("t4_gap%0d_armed", g), 32'(armed_a), 32'd0);
        end
        run_stream("t4_b", 0, "01", "01", 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("t4_after_z", 32'(z_a), 32'd0);

        // five overlapping matches; CNT_W=2 counter saturates at 3
        do_reset("t5");
        run_stream("t5", 1, "10101010101", "00101010101", 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk("t5_cnt_sat", 32'(cnt_c), 32'd3);
        chk("t5_cnt_wide", 32'(cnt_a), 32'd5);
`endif

        // LEN=5 pattern 11011 with overlap: pulses after bits 5 and 8
        do_reset("t6");
        run_stream("t6_a", 2, "1101", "0000", 1'b1);
        chk("t6_armed_bit4", 32'(armed_b), 32'd0);
        run_stream("t6_b", 2, "1", "1", 1'b1);
        chk("t6_armed_bit5", 32'(armed_b), 32'd1);
        run_stream("t6_c", 2, "011", "001", 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk("t6_cnt", 32'(cnt_b), 32'd2);
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
